// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^N), LSB first, one cell.
// Ports: clk, rst (sync high), start/a/b/bin in; busy, done, diff, bout out.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          r_br;
  logic [CW-1:0] r_cnt;
  logic [N-2:0]  r_res;
  logic [N-1:0]  r_diff;
  logic          r_bout;

  logic          w_load;
  logic          w_step;
  logic          w_last;
  logic          w_cnt_last;
  logic          w_ai;
  logic          w_bi;
  logic          w_d;
  logic          w_brn;
  logic [N-1:0]  w_res_nxt;

  assign w_cnt_last = (r_cnt == CW'(N - 1));

  // full-subtractor cell on the current LSBs
  assign w_ai  = r_a[0];
  assign w_bi  = r_b[0];
  assign w_d   = w_ai ^ w_bi ^ r_br;
  assign w_brn = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);

  // new bit enters at the MSB; after N steps bit 0 lands at position 0
  assign w_res_nxt = {w_d, r_res};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (w_cnt_last) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else begin
      if (w_load) begin
        r_a   <= a;
        r_b   <= b;
        r_br  <= bin;
        r_cnt <= '0;
        r_res <= '0;
      end else if (w_step) begin
        r_a   <= {1'b0, r_a[N-1:1]};
        r_b   <= {1'b0, r_b[N-1:1]};
        r_br  <= w_brn;
        r_cnt <= r_cnt + CW'(1);
        r_res <= w_res_nxt[N-1:1];
      end
      if (w_last) begin
        r_diff <= w_res_nxt;
        r_bout <= w_brn;
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=8).
// Vector table, hand sequences, and random ops vs arithmetic model.
module tb_serial_subtractor;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;

  int nvec;
  int nerr;

  serial_subtractor #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] va;
    logic [N-1:0] vb;
    logic         vbin;
    logic [N-1:0] ed;
    logic         eb;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // {borrow, diff} from plain integer arithmetic
  function automatic logic [N:0] ref_sub(input logic [N-1:0] x,
                                         input logic [N-1:0] y,
                                         input logic c);
    int r;
    logic [N-1:0] d;
    r = int'(x) - int'(y) - int'(c);
    d = N'(r + (1 << N));
    return {(r < 0), d};
  endfunction

  // start at current negedge, scramble inputs afterwards, check result
  task automatic run_op(input logic [N-1:0] ta,
                        input logic [N-1:0] tb,
                        input logic tbin,
                        input logic [N-1:0] ed,
                        input logic eb);
    int k;
    int bcnt;
    int lat;
    bit seen;
    start = 1'b1;
    a = ta;
    b = tb;
    bin = tbin;
    @(negedge clk);
    k = 1;
    seen = 0;
    bcnt = 0;
    lat = 0;
    while (!seen && k <= N + 4) begin
      check("busy_done_excl", {31'd0, busy & done}, 0);
      if (busy) bcnt++;
      if (done) begin
        seen = 1;
        lat = k;
      end else begin
        start = 1'($urandom);
        a = N'($urandom);
        b = N'($urandom);
        bin = 1'($urandom);
        @(negedge clk);
        k++;
      end
    end
    check("done_seen", {31'd0, seen}, 1);
    if (seen) begin
      check("diff", {24'd0, diff}, {24'd0, ed});
      check("bout", {31'd0, bout}, {31'd0, eb});
      check("latency", lat, N + 1);
      check("busy_cycles", bcnt, N);
    end
    start = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    check("done_pulse_1cyc", {31'd0, done}, 0);
    check("idle_after_done", {31'd0, busy}, 0);
    check("diff_hold", {24'd0, diff}, {24'd0, ed});
  endtask

  initial begin
    logic [N:0] m;
    logic [N:0] q[$];
    int accq[$];
    int next_acc;
    int ndone;
    logic [N:0] e;
    int ac;

    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;

    tbl[0]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    tbl[1]  = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    tbl[2]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    tbl[3]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[4]  = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    tbl[5]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    tbl[6]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    tbl[7]  = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0};
    tbl[8]  = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
    tbl[9]  = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
    tbl[10] = '{8'hFF, 8'hFE, 1'b1, 8'h00, 1'b0};

    // reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_diff", {24'd0, diff}, 0);
    check("rst_bout", {31'd0, bout}, 0);

    // idle with start low stays idle
    @(negedge clk);
    @(negedge clk);
    check("idle_hold_busy", {31'd0, busy}, 0);
    check("idle_hold_diff", {24'd0, diff}, 0);

    // directed table
    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].va, tbl[i].vb, tbl[i].vbin, tbl[i].ed, tbl[i].eb);
    end

    // reset beats start in the same cycle
    rst = 1'b1;
    start = 1'b1;
    a = 8'h12;
    b = 8'h01;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rst_prio_busy", {31'd0, busy}, 0);
    check("rst_prio_diff", {24'd0, diff}, 0);
    @(negedge clk);
    check("rst_prio_dropped", {31'd0, busy}, 0);

    // start held high with operands changing every cycle
    next_acc = 0;
    ndone = 0;
    for (int cyc = 0; cyc < 4 * (N + 2); cyc++) begin
      check("hold_excl", {31'd0, busy & done}, 0);
      if (done) begin
        ndone++;
        if (q.size() == 0) begin
          check("hold_extra_done", 1, 0);
        end else begin
          e = q.pop_front();
          ac = accq.pop_front();
          check("hold_diff", {24'd0, diff}, {24'd0, e[N-1:0]});
          check("hold_bout", {31'd0, bout}, {31'd0, e[N]});
          check("hold_lat", cyc - ac, N + 1);
        end
      end
      start = 1'b1;
      a = N'($urandom);
      b = N'($urandom);
      bin = 1'($urandom);
      if (cyc == next_acc) begin
        q.push_back(ref_sub(a, b, bin));
        accq.push_back(cyc);
        next_acc = next_acc + N + 2;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("hold_ndone", ndone, 4);
    check("hold_pending", q.size(), 0);
    @(negedge clk);
    @(negedge clk);

    // abort mid-operation with reset
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    start = 1'b1;
    a = 8'h33;
    b = 8'h11;
    bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_diff", {24'd0, diff}, 0);
    check("abort_bout", {31'd0, bout}, 0);
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

    // random operations
    for (int i = 0; i < 1000; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      logic rc;
      ra = N'($urandom);
      rb = N'($urandom);
      rc = 1'($urandom);
      m = ref_sub(ra, rb, rc);
      run_op(ra, rb, rc, m[N-1:0], m[N]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter N, default 8, giving operand width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, N bits: minuend, captured on the accepted start edge.
REQ-006 The block SHALL have port b, input, N bits: subtrahend, captured on the accepted start edge.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in, captured on the accepted start edge.
REQ-008 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port diff, output, N bits: registered result a - b - bin, modulo 2^N.
REQ-011 The block SHALL have port bout, output, 1 bit: registered borrow-out of the MSB stage.

Function
REQ-012 The block SHALL compute the difference bit-serially, LSB first, with one full-subtractor cell and a borrow flip-flop.
REQ-013 Per-bit cell SHALL give: d = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-015 IDLE: busy=0, done=0; start=1 at edge E0 loads a and b into shift registers, bin into the borrow flop, count=0; next state SHIFT.
REQ-016 IDLE with start=0 SHALL stay in IDLE with all registers held.
REQ-017 SHIFT: busy=1; each edge consumes operand bit[count], shifts d into the MSB of the internal result register, updates the borrow, and increments count.
REQ-018 SHIFT SHALL last exactly N edges (E1..EN); at EN, where count==N-1, next state is DONE.
REQ-019 At edge EN, diff SHALL load the completed N-bit result and bout SHALL load the final borrow.
REQ-020 DONE: done=1 and busy=0 for exactly one cycle; next state IDLE unconditionally.
REQ-021 done SHALL be high in the cycle after EN, N cycles after the start edge E0; throughput SHALL be one operation per N+2 cycles.
REQ-022 diff and bout SHALL hold their values from EN until the next completion or reset.
REQ-023 start SHALL be ignored in SHIFT and DONE; changes on a, b, bin after E0 SHALL NOT affect the result.
REQ-024 busy and done SHALL never be high in the same cycle.
REQ-025 Arithmetic SHALL wrap modulo 2^N; bout=1 exactly when a < b + bin as unsigned integers.

Reset
REQ-026 rst=1 at a rising edge SHALL force state IDLE, busy=0, done=0, diff=0, bout=0, count=0, and clear the borrow flop and shift registers.
REQ-027 rst SHALL take priority over start in the same cycle; the start SHALL be dropped.
REQ-028 rst during SHIFT or DONE SHALL abort the operation with no done pulse; the block SHALL accept start in the first cycle after rst deasserts.

Verification
REQ-029 With N=8, a=0x05, b=0x03, bin=0, start pulse at E0 -> done high only in the cycle after E8, diff=0x02, bout=0; busy high for exactly 8 cycles.
REQ-030 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1.
REQ-031 a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1; then a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1; then a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0.
REQ-032 Hold start=1 continuously and change a, b every cycle -> operations accepted only every 10 cycles, each result matches operands captured at acceptance, no second done during busy.
REQ-033 Assert rst at E4 of an operation -> busy=0, diff=0x00, bout=0 next cycle, no done pulse; a fresh start afterwards (a=0x80, b=0x01) -> diff=0x7F, bout=0.
REQ-034 The bench SHALL also run 1000 random (a, b, bin) operations against the reference a - b - bin, checking diff and bout at every done pulse.
